// File: rtl/noc_input_buffer_pkg.sv
// Shared NoC parameters: flit/coordinate widths, header field offsets,
// output-direction codes, the buffered flit entry layout and the XY route
// function. Reused by the router input buffer and the switch allocator.
package noc_input_buffer_pkg;

    localparam int Noc_Data_Width = 32;
    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;

    // Header flit field offsets (destination X in the low bits, Y above it).
    localparam int Noc_Hdr_X_Lsb = 0;
    localparam int Noc_Hdr_Y_Lsb = Noc_ID_X_Width;

    // Output direction codes.
    localparam logic [2:0] Noc_Port_Local = 3'd0;
    localparam logic [2:0] Noc_Port_East  = 3'd1;
    localparam logic [2:0] Noc_Port_West  = 3'd2;
    localparam logic [2:0] Noc_Port_North = 3'd3;
    localparam logic [2:0] Noc_Port_South = 3'd4;

    typedef enum logic {
        FRM_IDLE = 1'b0,
        FRM_BODY = 1'b1
    } frm_state_e;

    // One buffered flit: payload, framing flags and the packet's direction.
    typedef struct packed {
        logic [Noc_Data_Width-1:0] flit;
        logic                      is_header;
        logic                      is_tail;
        logic [2:0]                route;
    } flit_entry_t;

    // Dimension-ordered routing: resolve X first, then Y; unsigned compares.
    function automatic logic [2:0] xy_route(
        input logic [Noc_ID_X_Width-1:0] dest_x,
        input logic [Noc_ID_Y_Width-1:0] dest_y,
        input logic [Noc_ID_X_Width-1:0] my_x,
        input logic [Noc_ID_Y_Width-1:0] my_y
    );
        if (dest_x > my_x)      return Noc_Port_East;
        else if (dest_x < my_x) return Noc_Port_West;
        else if (dest_y > my_y) return Noc_Port_North;
        else if (dest_y < my_y) return Noc_Port_South;
        else                    return Noc_Port_Local;
    endfunction

endpackage

// File: rtl/noc_input_buffer_flit_fifo.sv
// noc_flit_fifo: generic DEPTH-entry register FIFO (DEPTH a power of two).
// Ports: clk_i/rst_ni; write side wr_vld_i/wr_dat_i (ignored when full);
// read side rd_vld_o/rd_dat_o/rd_rdy_i; count_o is the registered entry count.
module noc_flit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_vld_i,
    input  logic [WIDTH-1:0]           wr_dat_i,
    output logic                       rd_vld_o,
    output logic [WIDTH-1:0]           rd_dat_o,
    input  logic                       rd_rdy_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    // A write at full is refused even if a read happens in the same cycle.
    assign wr_en = wr_vld_i && (count_q != CW'(DEPTH));
    assign rd_en = rd_rdy_i && (count_q != '0);

    assign wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d  = count_q + CW'(wr_en) - CW'(rd_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
            end
        end
    end

    assign rd_vld_o = (count_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;

endmodule

// File: rtl/noc_input_buffer.sv
// Router input-port buffer: checks wormhole framing, computes the XY output
// direction from headers and queues flit+flags+route in a DEPTH-entry FIFO.
// Ports: in_* upstream valid/ready flit stream; out_* head entry with route;
// framing_error pulses for each dropped flit; occupancy is the entry count.
module noc_input_buffer
    import noc_input_buffer_pkg::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] X_ID  = '0,
    parameter logic [Noc_ID_Y_Width-1:0] Y_ID  = '0,
    parameter int                        DEPTH = 4
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [Noc_Data_Width-1:0] in_flit,
    input  logic                      in_is_header,
    input  logic                      in_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Noc_Data_Width-1:0] out_flit,
    output logic                      out_is_header,
    output logic                      out_is_tail,
    output logic [2:0]                out_route,
    output logic                      framing_error,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    frm_state_e  state_q, state_d;
    logic [2:0]  route_q, route_d;
    logic        framing_error_q;
    logic        accept, enq, drop;
    logic [2:0]  hdr_route;
    flit_entry_t wr_entry, rd_entry;
    logic [CW-1:0] count;

    assign in_ready = (count != CW'(DEPTH));
    assign accept   = in_valid && in_ready;

    assign hdr_route = xy_route(in_flit[Noc_Hdr_X_Lsb +: Noc_ID_X_Width],
                                in_flit[Noc_Hdr_Y_Lsb +: Noc_ID_Y_Width],
                                X_ID, Y_ID);

    // Framing: mis-framed flits are still handshaked (so upstream drains)
    // but never enter the FIFO.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        enq     = 1'b0;
        drop    = 1'b0;
        if (accept) begin
            case (state_q)
                FRM_IDLE: begin
                    if (in_is_header) begin
                        enq     = 1'b1;
                        route_d = hdr_route;
                        if (!in_is_tail) state_d = FRM_BODY;
                    end else begin
                        drop = 1'b1;
                    end
                end
                FRM_BODY: begin
                    if (in_is_header) begin
                        drop = 1'b1;
                    end else begin
                        enq = 1'b1;
                        if (in_is_tail) state_d = FRM_IDLE;
                    end
                end
                default: state_d = FRM_IDLE;
            endcase
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q         <= FRM_IDLE;
            route_q         <= Noc_Port_Local;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            route_q         <= route_d;
            framing_error_q <= drop;
        end
    end

    // Header carries its own freshly computed route; body/tail use the stored one.
    always_comb begin
        wr_entry           = '0;
        wr_entry.flit      = in_flit;
        wr_entry.is_header = in_is_header;
        wr_entry.is_tail   = in_is_tail;
        wr_entry.route     = in_is_header ? hdr_route : route_q;
    end

    noc_flit_fifo #(
        .WIDTH ($bits(flit_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (noc_clk),
        .rst_ni   (noc_rst_n),
        .wr_vld_i (enq),
        .wr_dat_i (wr_entry),
        .rd_vld_o (out_valid),
        .rd_dat_o (rd_entry),
        .rd_rdy_i (out_ready),
        .count_o  (count)
    );

    assign out_flit      = rd_entry.flit;
    assign out_is_header = rd_entry.is_header;
    assign out_is_tail   = rd_entry.is_tail;
    assign out_route     = rd_entry.route;
    assign framing_error = framing_error_q;
    assign occupancy     = count;

endmodule

// File: tb/tb_noc_input_buffer.sv
module tb_noc_input_buffer;
    import noc_input_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic                      noc_clk = 1'b0;
    logic                      noc_rst_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [Noc_Data_Width-1:0] in_flit = '0;
    logic                      in_is_header = 1'b0;
    logic                      in_is_tail = 1'b0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [Noc_Data_Width-1:0] out_flit;
    logic                      out_is_header;
    logic                      out_is_tail;
    logic [2:0]                out_route;
    logic                      framing_error;
    logic [$clog2(DEPTH):0]    occupancy;

    noc_input_buffer #(
        .X_ID  (4'd1),
        .Y_ID  (4'd1),
        .DEPTH (DEPTH)
    ) dut (
        .noc_clk       (noc_clk),
        .noc_rst_n     (noc_rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_is_header  (in_is_header),
        .in_is_tail    (in_is_tail),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_flit      (out_flit),
        .out_is_header (out_is_header),
        .out_is_tail   (out_is_tail),
        .out_route     (out_route),
        .framing_error (framing_error),
        .occupancy     (occupancy)
    );

    always #5 noc_clk = ~noc_clk;

    flit_entry_t sb[$];
    int          total = 0;
    int          bad = 0;
    bit          mdl_body = 1'b0;
    logic [2:0]  mdl_route = 3'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int seq, input logic [3:0] dx, input logic [3:0] dy);
        logic [7:0] s;
        s = seq[7:0];
        return {16'hC0DE, s, dy, dx};
    endfunction

    // One clock cycle: drive inputs, check pre-edge state against the
    // scoreboard, advance the model, clock, then check framing_error.
    task automatic cycle(input logic v, input logic [31:0] f, input logic h, input logic t,
                         input logic [2:0] er, input logic ordy);
        flit_entry_t e;
        bit acc, pop, enq, drop;
        in_valid = v; in_flit = f; in_is_header = h; in_is_tail = t; out_ready = ordy;
        #1;
        check("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
        check("occupancy", 64'(occupancy), 64'(sb.size()));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_flit", 64'(out_flit), 64'(sb[0].flit));
            check("out_is_header", 64'(out_is_header), 64'(sb[0].is_header));
            check("out_is_tail", 64'(out_is_tail), 64'(sb[0].is_tail));
            check("out_route", 64'(out_route), 64'(sb[0].route));
        end
        pop  = (sb.size() != 0) && ordy;
        acc  = v && (sb.size() != DEPTH);
        enq  = 1'b0;
        drop = 1'b0;
        e.flit = f; e.is_header = h; e.is_tail = t;
        e.route = h ? er : mdl_route;
        if (acc) begin
            if (!mdl_body) begin
                if (h) begin enq = 1'b1; mdl_route = er; mdl_body = !t; end
                else drop = 1'b1;
            end else begin
                if (h) drop = 1'b1;
                else begin enq = 1'b1; if (t) mdl_body = 1'b0; end
            end
        end
        @(posedge noc_clk);
        #1;
        if (pop) void'(sb.pop_front());
        if (enq) sb.push_back(e);
        check("framing_error", 64'(framing_error), 64'(drop));
        in_valid = 1'b0;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && sb.size() != 0; i++) idle(1'b1);
        idle(1'b1);
    endtask

    task automatic do_reset();
        noc_rst_n = 1'b0;
        in_valid  = 1'b0;
        #3;
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_flit", 64'(out_flit), 64'd0);
        check("rst_out_is_header", 64'(out_is_header), 64'd0);
        check("rst_out_is_tail", 64'(out_is_tail), 64'd0);
        check("rst_out_route", 64'(out_route), 64'd0);
        check("rst_framing_error", 64'(framing_error), 64'd0);
        sb.delete();
        mdl_body  = 1'b0;
        mdl_route = 3'd0;
        @(posedge noc_clk);
        #1;
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        #1;
    endtask

    initial begin
        #1;
        do_reset();

        // Single-flit packet to self: LOCAL, visible the cycle after acceptance.
        cycle(1'b1, hdr(1, 4'd1, 4'd1), 1'b1, 1'b1, 3'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // 4-flit packet to (2,1) held back: fills to DEPTH, then drains in order.
        cycle(1'b1, hdr(2, 4'd2, 4'd1), 1'b1, 1'b0, 3'd1, 1'b0);
        cycle(1'b1, 32'hB0D1_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'hB0D1_0002, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'hB0D1_0003, 1'b0, 1'b1, 3'd0, 1'b0);
        idle(1'b0);
        drain();

        // Back-to-back packets: SOUTH then WEST, routes carried by body/tail.
        cycle(1'b1, hdr(3, 4'd1, 4'd0), 1'b1, 1'b0, 3'd4, 1'b1);
        cycle(1'b1, 32'hB0D3_0001, 1'b0, 1'b0, 3'd0, 1'b1);
        cycle(1'b1, 32'hB0D3_0002, 1'b0, 1'b1, 3'd0, 1'b1);
        cycle(1'b1, hdr(4, 4'd0, 4'd3), 1'b1, 1'b0, 3'd2, 1'b1);
        cycle(1'b1, 32'hB0D4_0001, 1'b0, 1'b0, 3'd0, 1'b1);
        cycle(1'b1, 32'hB0D4_0002, 1'b0, 1'b1, 3'd0, 1'b1);
        drain();

        // Framing errors: body in IDLE dropped, header inside BODY dropped.
        cycle(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, hdr(5, 4'd1, 4'd2), 1'b1, 1'b0, 3'd3, 1'b0);
        cycle(1'b1, hdr(6, 4'd3, 4'd3), 1'b1, 1'b0, 3'd1, 1'b0);
        cycle(1'b1, 32'hB0D5_0001, 1'b0, 1'b1, 3'd0, 1'b0);
        idle(1'b0);
        drain();

        // Full buffer with simultaneous offer and read: only the read happens,
        // then the re-offered flit is written while another is read.
        cycle(1'b1, hdr(7, 4'd0, 4'd1), 1'b1, 1'b0, 3'd2, 1'b0);
        cycle(1'b1, 32'hB0D7_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'hB0D7_0002, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'hB0D7_0003, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 32'hB0D7_0004, 1'b0, 1'b1, 3'd0, 1'b1);
        cycle(1'b1, 32'hB0D7_0004, 1'b0, 1'b1, 3'd0, 1'b1);
        idle(1'b0);
        drain();

        // Reset mid-packet: buffer empties, the orphaned tail is mis-framed.
        cycle(1'b1, hdr(8, 4'd2, 4'd2), 1'b1, 1'b0, 3'd1, 1'b0);
        cycle(1'b1, 32'hB0D8_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        do_reset();
        cycle(1'b1, 32'hB0D8_0002, 1'b0, 1'b1, 3'd0, 1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/noc_input_buffer.md
# noc_input_buffer

Router input-port buffer that consumes the flit stream produced by a NoC endpoint node's sender port (or a neighbouring router's output). It checks wormhole packet framing, computes the XY output direction from each header flit, and holds flits in a small FIFO with valid/ready on both sides. The downstream switch allocator reads each flit together with its latched output direction.

## Interface
Parameters:
- X_ID, 0, X coordinate of this router (`Noc_ID_X_Width` bits)
- Y_ID, 0, Y coordinate of this router (`Noc_ID_Y_Width` bits)
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- noc_clk  input  1  single clock; all logic rising-edge
- noc_rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream flit valid
- in_ready  output  1  buffer can take a flit
- in_flit  input  `Noc_Data_Width`  upstream flit
- in_is_header  input  1  flit is packet header
- in_is_tail  input  1  flit is packet tail
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head entry
- out_flit  output  `Noc_Data_Width`  head flit
- out_is_header  output  1  head flit header flag
- out_is_tail  output  1  head flit tail flag
- out_route  output  3  output direction of head flit's packet
- framing_error  output  1  one-cycle pulse on a dropped mis-framed flit
- occupancy  output  $clog2(DEPTH)+1  current entry count

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = (occupancy != DEPTH); independent of in_valid; no same-cycle pass-through at full.
- Header layout: dest X = in_flit[`Noc_ID_X_Width-1:0]; dest Y = in_flit[`Noc_ID_X_Width+`Noc_ID_Y_Width-1:`Noc_ID_X_Width].
- XY route on header: destX>X_ID → EAST(1); destX<X_ID → WEST(2); else destY>Y_ID → NORTH(3); destY<Y_ID → SOUTH(4); else LOCAL(0). Comparisons unsigned.
- Route register: loaded from accepted header; body/tail flits take stored route. Route stored per FIFO entry with the flit and flags.
- Framing FSM (input side), states IDLE, BODY:
  - IDLE + header, not tail → enqueue, BODY.
  - IDLE + header+tail (single-flit packet) → enqueue, stay IDLE.
  - IDLE + non-header → flit accepted (handshake completes) but not enqueued; framing_error pulse; stay IDLE.
  - BODY + non-header, not tail → enqueue, stay BODY.
  - BODY + tail (no header) → enqueue, IDLE.
  - BODY + header → accepted, dropped, framing_error; stay BODY.
- Dropped flits still need in_ready high; occupancy unchanged.
- Simultaneous read and write with 0<occupancy<DEPTH: occupancy unchanged. At occupancy==DEPTH, only the read occurs.
- Reset mid-packet: FIFO emptied, FSM → IDLE, route register → LOCAL; the remainder of the interrupted packet is treated as mis-framed.

## Timing
- Reset values: out_valid 0, out_flit 0, out_is_header 0, out_is_tail 0, out_route 0, framing_error 0, occupancy 0, in_ready 1.
- Latency: flit accepted at edge N is on out_* with out_valid=1 after edge N (visible cycle N+1); minimum 1 cycle, no combinational in→out path.
- out_* stable while out_valid && !out_ready.
- framing_error asserted for exactly the cycle after the dropping edge; registered.
- in_ready, occupancy, out_valid derive only from registers.
- Full throughput: one flit per cycle sustained when out_ready held high.

## Structure
- Direction codes LOCAL/EAST/WEST/NORTH/SOUTH (`Noc_Port_*`, 3 bits) and header X/Y field offsets go into the shared Noc_parameters include, for reuse by the switch allocator.
- One sub-module: noc_flit_fifo (generic DEPTH-entry register FIFO; payload = flit + header + tail + route). Framing FSM and route compute stay in the top.

## Test plan
- X_ID=1,Y_ID=1, DEPTH=4: single header+tail flit, dest (1,1) → one output, out_route=0, header=tail=1, latency 1 cycle.
- 4-flit packet to dest (2,1), out_ready low 3 cycles → all 4 flits out in order with out_route=1, occupancy peaks at 4, in_ready low at 4.
- Packet to (1,0) then (0,3) back-to-back → routes 4 then 2, each held across its body flits.
- Body flit in IDLE, then header inside BODY → both dropped, two framing_error pulses, occupancy unchanged, subsequent tail enqueued.
- Occupancy 4, in_valid and out_ready both high → no write, one read, occupancy 3; next cycle write+read keeps 3.
- noc_rst_n low after header + 1 body flit → occupancy 0, out_valid 0; subsequent tail flagged framing_error.
